// File: rtl/axis_spi_master_if.sv
// AXI-Stream TX/RX channel bundle for the SPI master engine.
// The slave modport is the engine's view; the master modport is the upstream/downstream peer's view.
interface axis_spi_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_spi_master.sv
// SPI master shift engine: AXI-Stream TX bytes out on MOSI, MISO bytes back on AXI-Stream, SPI modes 0-3.
// Optional macro AXIS_SPI_TLAST_CS_EN keeps CS low across bytes until a byte carrying s_axis_tlast completes.
module axis_spi_master #(
    parameter int DATA_WIDTH    = 8,
    parameter int DIVIDER_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic                     cpol_i,
    input  logic                     cpha_i,
    axis_spi_master_if.slave         axis,
    output logic                     spi_sclk_o,
    output logic                     spi_cs_n_o,
    output logic                     spi_mosi_o,
    input  logic                     spi_miso_i
);
    localparam int                EDGE_W    = $clog2(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state_q, state_d;

    logic [DIVIDER_WIDTH-1:0] div_q;
    logic [DIVIDER_WIDTH-1:0] div_cnt_q;
    logic [EDGE_W-1:0]        edge_cnt_q;
    logic [DATA_WIDTH-1:0]    tx_sr_q;
    logic [DATA_WIDTH-1:0]    rx_sr_q;
    logic [DATA_WIDTH-1:0]    rx_data_q;
    logic                     rx_valid_q;
    logic                     ready_en_q;
    logic                     cpol_q;
    logic                     cpha_q;
    logic                     tlast_q;
    logic                     sclk_q;
    logic                     cs_n_q;
    logic                     mosi_q;
    logic                     tick;
    logic                     last_edge;
    logic                     tx_ready;
    logic                     accept;
    logic                     cs_held;
    logic                     frame_end;

`ifdef AXIS_SPI_TLAST_CS_EN
    assign cs_held   = !cs_n_q;
    assign frame_end = tlast_q;
`else
    logic unused_tlast;
    assign unused_tlast = tlast_q;
    assign cs_held      = 1'b0;
    assign frame_end    = 1'b1;
`endif

    assign tick      = (div_cnt_q == div_q - DIVIDER_WIDTH'(1));
    assign last_edge = (edge_cnt_q == EDGE_LAST);
    assign accept    = tx_ready && axis.s_axis_tvalid;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // ready_en_q keeps s_axis_tready low until the first clock after reset release
    always_comb begin
        state_d  = state_q;
        tx_ready = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = ready_en_q && !rx_valid_q;
                if (tx_ready && axis.s_axis_tvalid) state_d = cs_held ? SHIFT : SETUP;
            end
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: if (tick && last_edge) state_d = HOLD;
            HOLD:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            div_q      <= DIVIDER_WIDTH'(1);
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ready_en_q <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tlast_q    <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (rx_valid_q && axis.m_axis_tready) rx_valid_q <= 1'b0;

            if (state_q == IDLE || tick) div_cnt_q <= '0;
            else                         div_cnt_q <= div_cnt_q + DIVIDER_WIDTH'(1);

            case (state_q)
                IDLE: begin
                    sclk_q     <= cs_n_q ? cpol_i : cpol_q;
                    edge_cnt_q <= '0;
                    if (accept) begin
                        cpol_q  <= cpol_i;
                        cpha_q  <= cpha_i;
                        tlast_q <= axis.s_axis_tlast;
                        div_q   <= (clk_divider_i == '0) ? DIVIDER_WIDTH'(1) : clk_divider_i;
                        // cpha=0 already presents the MSB, so the register starts one bit ahead
                        tx_sr_q <= cpha_i ? axis.s_axis_tdata : (axis.s_axis_tdata << 1);
                        mosi_q  <= axis.s_axis_tdata[DATA_WIDTH-1];
                        cs_n_q  <= 1'b0;
                        sclk_q  <= cpol_i;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
                        // even edge count = leading edge; sample edge is leading for cpha=0
                        if (edge_cnt_q[0] == cpha_q) begin
                            rx_sr_q <= {rx_sr_q[DATA_WIDTH-2:0], spi_miso_i};
                        end else begin
                            mosi_q  <= tx_sr_q[DATA_WIDTH-1];
                            tx_sr_q <= tx_sr_q << 1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sr_q;
                        if (frame_end) cs_n_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign axis.s_axis_tready = tx_ready;
    assign axis.m_axis_tdata  = rx_data_q;
    assign axis.m_axis_tvalid = rx_valid_q;
    assign spi_sclk_o         = sclk_q;
    assign spi_cs_n_o         = cs_n_q;
    assign spi_mosi_o         = mosi_q;
endmodule

// File: tb/tb_axis_spi_master.sv
// Directed bench for axis_spi_master: reset values, modes, divider edge cases, RX back-pressure,
// mid-transfer reset and CS framing (adapts to AXIS_SPI_TLAST_CS_EN).
module tb_axis_spi_master;
    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic [31:0] clk_divider;
    logic        cpol;
    logic        cpha;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        loopback;
    logic [7:0]  slave_byte;
    logic [7:0]  slave_sr;
    logic [7:0]  mosi_cap;
    logic [7:0]  rx_byte;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          acc_cyc = 0;
    int          cs_rises = 0;
    int          lat;
    int          lat_div0;
    int          lat_div1;
    int          exp_rises;
    logic        exp_cs_mid;
    logic        ready_seen;
    logic        rx_stable;
    time         last_rise = 0;
    time         prev_rise = 0;

    axis_spi_master_if #(.DATA_WIDTH(8)) bus ();

    axis_spi_master #(.DATA_WIDTH(8), .DIVIDER_WIDTH(32)) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .clk_divider_i(clk_divider),
        .cpol_i       (cpol),
        .cpha_i       (cpha),
        .axis         (bus),
        .spi_sclk_o   (spi_sclk),
        .spi_cs_n_o   (spi_cs_n),
        .spi_mosi_o   (spi_mosi),
        .spi_miso_i   (spi_miso)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    // Mode-0 slave: MSB ready when CS falls, shifts on each falling SCLK edge
    always @(negedge spi_cs_n) slave_sr <= slave_byte;
    always @(negedge spi_sclk) if (!spi_cs_n) slave_sr <= slave_sr << 1;
    assign spi_miso = loopback ? spi_mosi : slave_sr[7];

    always @(posedge spi_sclk) begin
        if (!spi_cs_n) mosi_cap <= {mosi_cap[6:0], spi_mosi};
        prev_rise <= last_rise;
        last_rise <= $time;
    end

    always @(posedge spi_cs_n) cs_rises <= cs_rises + 1;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] data, input logic last);
        int n = 0;
        @(negedge clk_i);
        bus.s_axis_tdata  = data;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        while (!bus.s_axis_tready && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        check_output("tx_accept", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clk_i);
        #1;
        acc_cyc = cycle;
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_rx(output int latency);
        int n = 0;
        while (!bus.m_axis_tvalid && n < 5000) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check_output("rx_wait", 32'(bus.m_axis_tvalid), 32'd1);
        latency = cycle - acc_cyc + 1;
    endtask

    task automatic pop_rx(output logic [7:0] data);
        @(negedge clk_i);
        data = bus.m_axis_tdata;
        bus.m_axis_tready = 1'b1;
        @(posedge clk_i);
        #1;
        bus.m_axis_tready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        arstn_i           = 1'b0;
        clk_divider       = 32'd2;
        cpol              = 1'b1;
        cpha              = 1'b0;
        loopback          = 1'b1;
        slave_byte        = 8'h00;
        bus.s_axis_tdata  = 8'h00;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b0;

        // Reset values, with cpol=1 to show SCLK only follows cpol after release
        #12;
        check_output("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        check_output("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_output("rst_tdata", 32'(bus.m_axis_tdata), 32'h00);
        check_output("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check_output("rst_mosi", 32'(spi_mosi), 32'd0);
        check_output("rst_sclk", 32'(spi_sclk), 32'd0);
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("sclk_follows_cpol", 32'(spi_sclk), 32'd1);
        check_output("ready_after_rst", 32'(bus.s_axis_tready), 32'd1);
        cpol = 1'b0;
        repeat (3) @(negedge clk_i);

        // Mode 0, div 2, slave returns 0x3C
        loopback   = 1'b0;
        slave_byte = 8'h3C;
        apply_stimulus(8'hA5, 1'b1);
        wait_rx(lat);
        check_output("m0_latency", 32'(lat), 32'd37);
        check_output("m0_mosi", 32'(mosi_cap), 32'hA5);
        pop_rx(rx_byte);
        check_output("m0_rx", 32'(rx_byte), 32'h3C);
        check_output("m0_tvalid_clr", 32'(bus.m_axis_tvalid), 32'd0);
        loopback = 1'b1;

        // All four modes, div 3, loopback
        clk_divider = 32'd3;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk_i);
            cpol = m[1];
            cpha = m[0];
            repeat (2) @(negedge clk_i);
            check_output("mode_idle_sclk", 32'(spi_sclk), 32'(cpol));
            apply_stimulus(8'h81, 1'b1);
            wait_rx(lat);
            check_output("mode_latency", 32'(lat), 32'd55);
            pop_rx(rx_byte);
            check_output("mode_rx", 32'(rx_byte), 32'h81);
        end

        // div 1 and div 0 behave identically
        @(negedge clk_i);
        cpol = 1'b0;
        cpha = 1'b0;
        clk_divider = 32'd1;
        repeat (2) @(negedge clk_i);
        apply_stimulus(8'hFF, 1'b1);
        wait_rx(lat_div1);
        check_output("div1_period", 32'(last_rise - prev_rise), 32'd20);
        pop_rx(rx_byte);
        check_output("div1_rx", 32'(rx_byte), 32'hFF);
        check_output("div1_latency", 32'(lat_div1), 32'd19);
        clk_divider = 32'd0;
        apply_stimulus(8'hFF, 1'b1);
        wait_rx(lat_div0);
        check_output("div0_period", 32'(last_rise - prev_rise), 32'd20);
        pop_rx(rx_byte);
        check_output("div0_rx", 32'(rx_byte), 32'hFF);
        check_output("div0_eq_div1", 32'(lat_div0), 32'(lat_div1));

        // RX back-pressure with a second byte queued
        clk_divider = 32'd2;
        apply_stimulus(8'h11, 1'b1);
        wait_rx(lat);
        @(negedge clk_i);
        bus.s_axis_tdata  = 8'h22;
        bus.s_axis_tlast  = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        ready_seen = 1'b0;
        rx_stable  = 1'b1;
        repeat (100) begin
            @(negedge clk_i);
            if (bus.s_axis_tready) ready_seen = 1'b1;
            if (bus.m_axis_tdata !== 8'h11 || bus.m_axis_tvalid !== 1'b1) rx_stable = 1'b0;
        end
        check_output("bp_no_accept", 32'(ready_seen), 32'd0);
        check_output("bp_rx_stable", 32'(rx_stable), 32'd1);
        check_output("bp_rx_first", 32'(bus.m_axis_tdata), 32'h11);
        bus.m_axis_tready = 1'b1;
        @(posedge clk_i);
        #1;
        bus.m_axis_tready = 1'b0;
        @(negedge clk_i);
        check_output("bp_ready_after_pop", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clk_i);
        #1;
        acc_cyc = cycle;
        bus.s_axis_tvalid = 1'b0;
        wait_rx(lat);
        check_output("bp_latency", 32'(lat), 32'd37);
        pop_rx(rx_byte);
        check_output("bp_rx_second", 32'(rx_byte), 32'h22);

        // Reset around bit 4 of 0x5A, then a clean 0xC3
        apply_stimulus(8'h5A, 1'b1);
        repeat (18) @(posedge clk_i);
        #3;
        arstn_i = 1'b0;
        #1;
        check_output("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        check_output("midrst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check_output("midrst_tdata", 32'(bus.m_axis_tdata), 32'h00);
        repeat (2) @(negedge clk_i);
        arstn_i = 1'b1;
        apply_stimulus(8'hC3, 1'b1);
        wait_rx(lat);
        check_output("midrst_latency", 32'(lat), 32'd37);
        pop_rx(rx_byte);
        check_output("midrst_rx", 32'(rx_byte), 32'hC3);

        // CS framing over three bytes, tlast on the third
`ifdef AXIS_SPI_TLAST_CS_EN
        exp_rises  = 1;
        exp_cs_mid = 1'b0;
`else
        exp_rises  = 3;
        exp_cs_mid = 1'b1;
`endif
        clk_divider = 32'd1;
        repeat (2) @(negedge clk_i);
        cs_rises = 0;
        apply_stimulus(8'h01, 1'b0);
        wait_rx(lat);
        pop_rx(rx_byte);
        check_output("frame_rx1", 32'(rx_byte), 32'h01);
        check_output("frame_cs_mid1", 32'(spi_cs_n), 32'(exp_cs_mid));
        apply_stimulus(8'h02, 1'b0);
        wait_rx(lat);
        pop_rx(rx_byte);
        check_output("frame_rx2", 32'(rx_byte), 32'h02);
        check_output("frame_cs_mid2", 32'(spi_cs_n), 32'(exp_cs_mid));
        apply_stimulus(8'h03, 1'b1);
        wait_rx(lat);
        pop_rx(rx_byte);
        check_output("frame_rx3", 32'(rx_byte), 32'h03);
        repeat (2) @(negedge clk_i);
        check_output("frame_cs_end", 32'(spi_cs_n), 32'd1);
        check_output("frame_cs_pulses", 32'(cs_rises), 32'(exp_rises));

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
